mux_8to1: RTL and testbench

- 8-to-1 selector. Picks one of eight WIDTH-bit lanes packed on a single input bus, using a 3-bit select.
- Used as a generic datapath steering element.
- Output is combinational by default.
- With an optional output register, it becomes a 1-cycle-latency pipelined mux with clock enable and synchronous reset.

---
 rtl/mux_8to1.sv | 56 +++++
 tb/tb_mux_8to1.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux_8to1.sv
// 8-to-1 lane selector over a packed 8*WIDTH input bus.
// Define MUX_8TO1_OUTREG_EN for a registered output with clock enable and synchronous reset.
module mux_8to1 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2:0]         sel,
    input  logic [8*WIDTH-1:0] in,
    output logic [WIDTH-1:0]   y
);

    logic [WIDTH-1:0] lane [8];
    logic [WIDTH-1:0] lane_sel;

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign lane[k] = in[k*WIDTH +: WIDTH];
    end

    // An unknown select propagates as all-X rather than quietly picking lane 0.
    always_comb begin
        case (sel)
            3'd0:    lane_sel = lane[0];
            3'd1:    lane_sel = lane[1];
            3'd2:    lane_sel = lane[2];
            3'd3:    lane_sel = lane[3];
            3'd4:    lane_sel = lane[4];
            3'd5:    lane_sel = lane[5];
            3'd6:    lane_sel = lane[6];
            3'd7:    lane_sel = lane[7];
            default: lane_sel = {WIDTH{1'bx}};
        endcase
    end

`ifdef MUX_8TO1_OUTREG_EN
    logic [WIDTH-1:0] y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else if (en) begin
            y_q <= lane_sel;
        end
    end

    assign y = y_q;
`else
    // clk, rst and en only matter for the registered build.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, en};

    assign y = lane_sel;
`endif

endmodule

// File: tb/tb_mux_8to1.sv
// Self-checking bench for mux_8to1: WIDTH=1 and WIDTH=8 instances, queue scoreboard
// against a shift-and-mask reference; follows MUX_8TO1_OUTREG_EN like the design.
module tb_mux_8to1;

    typedef struct {
        logic       chk;
        logic [0:0] e1;
        logic [7:0] e8;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [2:0]  sel = 3'd0;
    logic [7:0]  in1 = 8'h00;
    logic [63:0] in8 = 64'h0;
    logic [0:0]  y1;
    logic [7:0]  y8;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   drive_done = 1'b0;

`ifdef MUX_8TO1_OUTREG_EN
    logic       m_valid = 1'b0;
    logic [0:0] m1 = 1'b0;
    logic [7:0] m8 = 8'h00;
`endif

    mux_8to1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .in(in1), .y(y1)
    );

    mux_8to1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .in(in8), .y(y8)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference: lane k is the WIDTH bits found k*WIDTH positions up the bus.
    function automatic logic [0:0] ref1(input logic [7:0] v, input logic [2:0] s);
        logic [7:0] t;
        t = v >> s;
        return t[0];
    endfunction

    function automatic logic [7:0] ref8(input logic [63:0] v, input logic [2:0] s);
        logic [63:0] t;
        t = v >> (int'(s) * 8);
        return t[7:0];
    endfunction

    // Driver: apply one cycle of stimulus and queue what y must show at the next negedge.
    task automatic step(input logic [7:0] i1, input logic [63:0] i8, input logic [2:0] s,
                        input logic e, input logic r);
        exp_t x;
        @(posedge clk);
        #1;
`ifdef MUX_8TO1_OUTREG_EN
        // The edge just passed sampled the previous cycle's inputs.
        if (rst) begin
            m1 = 1'b0;
            m8 = 8'h00;
            m_valid = 1'b1;
        end else if (en) begin
            m1 = ref1(in1, sel);
            m8 = ref8(in8, sel);
        end
`endif
        in1 = i1;
        in8 = i8;
        sel = s;
        en  = e;
        rst = r;
`ifdef MUX_8TO1_OUTREG_EN
        x.chk = m_valid;
        x.e1  = m1;
        x.e8  = m8;
`else
        x.chk = 1'b1;
        x.e1  = ref1(i1, s);
        x.e8  = ref8(i8, s);
`endif
        exp_q.push_back(x);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                if (x.chk) begin
                    n_checks++;
                    if (y1 === x.e1) n_pass++;
                    else $display("FAIL y_w1 sel=%0d in=%h: got %h expected %h", sel, in1, y1, x.e1);
                    n_checks++;
                    if (y8 === x.e8) n_pass++;
                    else $display("FAIL y_w8 sel=%0d in=%h: got %h expected %h", sel, in8, y8, x.e8);
                end
            end
        end
    end

    // Stimulus
    localparam logic [63:0] LANES8 = 64'h7766_5544_3322_1100;

    initial begin
        // Reset held for two cycles.
        step(8'b1010_1010, LANES8, 3'd0, 1'b1, 1'b1);
        step(8'b1010_1010, LANES8, 3'd0, 1'b1, 1'b1);

        // Sweep every select code.
        for (int s = 0; s < 8; s++) step(8'b1010_1010, LANES8, 3'(s), 1'b1, 1'b0);
        step(8'b1010_1010, LANES8, 3'd1, 1'b1, 1'b0);
        step(8'b1010_1010, LANES8, 3'd2, 1'b1, 1'b0);

        // Data change under a fixed select, then reset applied.
        step(8'b1010_1010, LANES8, 3'd3, 1'b1, 1'b0);
        step(8'b0000_0000, 64'h0, 3'd3, 1'b1, 1'b0);
        step(8'b0000_0000, 64'h0, 3'd3, 1'b1, 1'b1);
        step(8'b1010_1010, LANES8, 3'd3, 1'b1, 1'b1);

        // Clock-enable hold.
        step(8'b1010_1010, LANES8, 3'd1, 1'b1, 1'b0);
        step(8'b1010_1010, LANES8, 3'd0, 1'b0, 1'b0);
        step(8'b1010_1010, LANES8, 3'd0, 1'b0, 1'b0);
        step(8'b1010_1010, LANES8, 3'd0, 1'b0, 1'b0);
        step(8'b1010_1010, LANES8, 3'd0, 1'b1, 1'b0);
        step(8'b1010_1010, LANES8, 3'd0, 1'b1, 1'b0);

        // Mid-stream reset pulse with sel=7.
        step(8'b1010_1010, LANES8, 3'd7, 1'b1, 1'b0);
        step(8'b1010_1010, LANES8, 3'd7, 1'b1, 1'b0);
        step(8'b1010_1010, LANES8, 3'd7, 1'b1, 1'b1);
        step(8'b1010_1010, LANES8, 3'd7, 1'b1, 1'b0);
        step(8'b1010_1010, LANES8, 3'd7, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end
        drive_done = 1'b1;
    end

    // Final report
    initial begin
        int budget;
        budget = 0;
        while (!drive_done && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (drive_done && exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0", drive_done, exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
